// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: bitstream word handshake between a bitstream source
// (master) and the configuration-chain loader (slave).
interface ccff_chain_loader_if #(
   parameter int WORD_W = 8
) ();
   logic [WORD_W-1:0] bs_data;
   logic              bs_valid;
   logic              bs_ready;

   modport master (
      output bs_data,
      output bs_valid,
      input  bs_ready
   );

   modport slave (
      input  bs_data,
      input  bs_valid,
      output bs_ready
   );
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: accepts bitstream words and shifts them LSB first into a
// CCFF configuration chain, one bit per config_enable cycle, for exactly
// CHAIN_LEN bits per load. Bits beyond CHAIN_LEN in the last word are dropped.
// Optional feature macro CCFF_READBACK_EN: adds rb_data/rb_valid, which
// reassemble the bits returning on ccff_tail into words.
module ccff_chain_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 64
) (
   input  logic                prog_clk,
   input  logic                pReset,
   input  logic                start,
   ccff_chain_loader_if.slave  bs,
   output logic                ccff_head,
   input  logic                ccff_tail,
   output logic                config_enable,
   output logic                busy,
   output logic                done
`ifdef CCFF_READBACK_EN
   ,
   output logic [WORD_W-1:0]   rb_data,
   output logic                rb_valid
`endif
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int POS_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_WORD,
      SHIFT,
      DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [WORD_W-1:0] shift_reg, shift_next;
   logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [POS_W-1:0]  pos_reg, pos_next;
   logic              head_reg, head_next;
   logic              enable_reg, enable_next;
   logic              emit;
   logic [WORD_W-1:0] emit_word;

   assign bs.bs_ready    = (state_reg == WAIT_WORD);
   assign busy           = (state_reg == WAIT_WORD) || (state_reg == SHIFT);
   assign done           = (state_reg == DONE);
   assign ccff_head      = head_reg;
   assign config_enable  = enable_reg;

   // Next-state and datapath: every emitted bit is registered onto ccff_head
   // together with config_enable, so the first bit of an accepted word leaves
   // on the acceptance edge and no bubble appears between back-to-back words.
   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      pos_next     = pos_reg;
      head_next    = head_reg;
      enable_next  = 1'b0;
      emit         = 1'b0;
      emit_word    = shift_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next   = WAIT_WORD;
               bit_cnt_next = '0;
               pos_next     = '0;
            end
         end
         WAIT_WORD: begin
            if (bs.bs_valid) begin
               emit      = 1'b1;
               emit_word = bs.bs_data;
            end
         end
         SHIFT: begin
            emit = 1'b1;
         end
         DONE: begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            pos_next     = '0;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (emit) begin
         head_next    = emit_word[0];
         enable_next  = 1'b1;
         shift_next   = emit_word >> 1;
         bit_cnt_next = bit_cnt_reg + 1'b1;
         if (bit_cnt_reg == CNT_LAST) begin
            // chain full: any remaining bits of this word are dropped
            state_next = DONE;
            pos_next   = '0;
         end else if (pos_reg == POS_LAST) begin
            // word exhausted (pos is 0 at acceptance, so this also covers WORD_W == 1)
            state_next = WAIT_WORD;
            pos_next   = '0;
         end else begin
            state_next = SHIFT;
            pos_next   = pos_reg + 1'b1;
         end
      end
   end

   // State and datapath registers with asynchronous reset that aborts a load.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         pos_reg     <= '0;
         head_reg    <= 1'b0;
         enable_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         pos_reg     <= pos_next;
         head_reg    <= head_next;
         enable_reg  <= enable_next;
      end
   end

`ifdef CCFF_READBACK_EN
   logic [WORD_W-1:0] rb_acc_reg;
   logic [POS_W-1:0]  rb_pos_reg;
   logic [WORD_W-1:0] rb_word;

   assign rb_word = rb_acc_reg | (WORD_W'(ccff_tail) << rb_pos_reg);

   // Collect ccff_tail on each enable cycle; publish full words, and flush a
   // zero-padded partial word on the final chain bit (which lands in DONE).
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         rb_acc_reg <= '0;
         rb_pos_reg <= '0;
         rb_data    <= '0;
         rb_valid   <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (enable_reg) begin
            if ((rb_pos_reg == POS_LAST) || (state_reg == DONE)) begin
               rb_data    <= rb_word;
               rb_valid   <= 1'b1;
               rb_acc_reg <= '0;
               rb_pos_reg <= '0;
            end else begin
               rb_acc_reg <= rb_word;
               rb_pos_reg <= rb_pos_reg + 1'b1;
            end
         end
      end
   end
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
`endif

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 8: width of each incoming bitstream word.
REQ-002 SHALL have parameter CHAIN_LEN, default 64: total configuration-chain length in bits, including all I/O tiles on the chain.
REQ-003 SHALL have port prog_clk, input, 1: the single clock.
REQ-004 SHALL have port pReset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin a chain load.
REQ-006 SHALL have port bs_data, input, WORD_W: bitstream word; bit 0 is shifted first.
REQ-007 SHALL have port bs_valid, input, 1: bs_data is valid.
REQ-008 SHALL have port bs_ready, output, 1: the loader accepts bs_data this cycle.
REQ-009 SHALL have port ccff_head, output, 1: serial bit into the head of the configuration chain.
REQ-010 SHALL have port ccff_tail, input, 1: serial bit from the tail of the configuration chain.
REQ-011 SHALL have port config_enable, output, 1: chain shift enable to all tiles.
REQ-012 SHALL have port busy, output, 1: a load is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when the load completes.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_WORD, SHIFT and DONE.
REQ-015 IDLE SHALL move to WAIT_WORD on start=1; start SHALL be ignored in every other state.
REQ-016 bs_ready SHALL equal 1 only in WAIT_WORD; a word SHALL be accepted on bs_valid & bs_ready and latched into a shift register, and the FSM SHALL move to SHIFT.
REQ-017 SHIFT SHALL drive one bit per cycle onto registered ccff_head, LSB first; bit 0 of an accepted word SHALL appear on ccff_head in the cycle after acceptance.
REQ-018 A bit counter (width clog2(CHAIN_LEN+1)) SHALL increment per shifted bit; a word counter SHALL track the position within the word.
REQ-019 On the last bit of a word with the bit count below CHAIN_LEN, the FSM SHALL return to WAIT_WORD; bs_valid low SHALL stall with config_enable=0 and ccff_head holding its value.
REQ-020 When the bit count reaches CHAIN_LEN, the FSM SHALL go to DONE; excess bits in the final word (CHAIN_LEN not a multiple of WORD_W) SHALL be discarded.
REQ-021 config_enable SHALL be 1 exactly in cycles where ccff_head carries a valid new bit, giving exactly CHAIN_LEN enable cycles per load.
REQ-022 DONE SHALL assert done for one cycle and then return to IDLE; busy SHALL be 1 in WAIT_WORD and SHIFT.

Reset
REQ-023 pReset=1 SHALL asynchronously force IDLE, with ccff_head=0, config_enable=0, bs_ready=0, busy=0, done=0, all counters at 0 and readback outputs at 0.
REQ-024 Reset asserted mid-load SHALL abort the load with no done pulse; a new start SHALL restart from bit 0.

Configuration
REQ-025 With CCFF_READBACK_EN defined, the block SHALL add outputs rb_data[WORD_W] and rb_valid.
REQ-026 With CCFF_READBACK_EN defined, ccff_tail SHALL be sampled on every config_enable cycle, LSB first, and rb_valid SHALL pulse for one cycle per WORD_W sampled bits, plus once for any final partial word zero-padded in the MSBs.
REQ-027 Without CCFF_READBACK_EN, the readback ports and logic SHALL be absent and ccff_tail SHALL be unused.

Verification
REQ-028 Defaults; start, then 8 words 0x01..0x08 with bs_valid held high -> exactly 64 config_enable cycles; ccff_head sequence equals word bits LSB first; done pulses once; busy falls with done.
REQ-029 bs_valid dropped for 5 cycles between word 3 and word 4 -> config_enable=0 and ccff_head stable during the gap; total enable cycles are still 64.
REQ-030 CHAIN_LEN=12, WORD_W=8, words 0xA5 and 0xFF -> 12 bits shifted (0xA5, then 0xF); the upper nibble of the second word is never driven; done pulses once.
REQ-031 pReset pulsed after 20 shifted bits -> outputs return to zero immediately with no done pulse; a following start loads the full 64 bits.
REQ-032 start pulsed while busy -> no effect on the counters or the ccff_head sequence.
REQ-033 CCFF_READBACK_EN defined, ccff_tail tied to ccff_head delayed by 64 config_enable cycles, two back-to-back loads of 0x3C words -> the second load's rb_data words all read 0x3C.
